// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu_pkg
// Brief  : Shared types and helpers for the data-memory load/store master.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_lsu_pkg;

    localparam int LSU_XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Byte-lane mask for an access of 1<<sz bytes, before lane shifting.
    function automatic logic [7:0] size_mask(input size_e sz);
        logic [8:0] m;
        m = (9'd1 << (4'd1 << sz)) - 9'd1;
        return m[7:0];
    endfunction

    function automatic logic [LSU_XLEN-1:0] extend(input logic [LSU_XLEN-1:0] v,
                                                   input size_e sz,
                                                   input logic uns);
        case (sz)
            SZ_B:    return uns ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            SZ_H:    return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            SZ_W:    return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_master_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu_master_if
// Brief  : Core request/response channel plus memory port of the LSU master.
// Rev    : 1.0  initial release
// ============================================================================
interface dmem_lsu_master_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [DATA_BYTES-1:0] o_mem_wen;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport master (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
               i_req_wdata, i_rsp_ready, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
               o_mem_addr, o_mem_wdata, o_mem_wen
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
               i_req_wdata, i_rsp_ready, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
               o_mem_addr, o_mem_wdata, o_mem_wen
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu_extract.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu_extract
// Brief  : Combinational lane shift, size select and sign/zero extension.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_lsu_extract
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LANE_BITS  = $clog2(DATA_WIDTH / 8)
) (
    input  wire logic [DATA_WIDTH-1:0] i_rdata,
    input  wire logic [LANE_BITS-1:0]  i_lane,
    input  wire size_e                 i_size,
    input  wire logic                  i_unsigned,
    output logic      [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [LSU_XLEN-1:0]   w_wide;
    logic [LSU_XLEN-1:0]   w_ext;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};
    assign w_wide    = LSU_XLEN'(w_shifted);
    assign w_ext     = extend(w_wide, i_size, i_unsigned);
    assign o_data    = DATA_WIDTH'(w_ext);
endmodule
`default_nettype wire

// File: rtl/dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu_master
// Brief  : Load/store initiator for a single-port synchronous data memory.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_lsu_master
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int LANE_BITS  = $clog2(DATA_BYTES)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dmem_lsu_master_if.master  bus
);
    state_e                r_state;
    logic [LANE_BITS-1:0]  r_lane;
    size_e                 r_size;
    logic                  r_uns;
    logic                  r_we;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_hold;

    logic [LANE_BITS-1:0]  w_lane;
    logic [LANE_BITS-1:0]  w_amask;
    size_e                 w_size;
    logic                  w_misalign;
    logic                  w_accept;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_live;

    assign w_lane     = bus.i_req_addr[LANE_BITS-1:0];
    assign w_size     = size_e'(bus.i_req_size);
    assign w_amask    = LANE_BITS'((32'd1 << bus.i_req_size) - 32'd1);
    assign w_misalign = ((w_lane & w_amask) != '0) || (32'(bus.i_req_size) > LANE_BITS);

    assign bus.o_req_ready = (r_state == ST_IDLE) | bus.i_rsp_ready;
    assign w_accept        = bus.i_req_valid & bus.o_req_ready;
    assign w_issue         = w_accept & ~w_misalign;

    // Bus is forced to zero whenever nothing is issued: addresses can have read side effects.
    assign w_addr          = w_issue ? bus.i_req_addr : '0;
    assign bus.o_mem_addr  = w_addr;
    assign bus.o_mem_wdata = w_issue ? (bus.i_req_wdata << {w_lane, 3'b000}) : '0;
    assign bus.o_mem_wen   = (w_issue & bus.i_req_we)
                             ? (DATA_BYTES'(size_mask(w_size)) << w_lane) : '0;

    dmem_lsu_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_BITS  (LANE_BITS)
    ) u_extract (
        .i_rdata    (bus.i_mem_rdata),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

    assign w_live          = (r_we | r_err) ? '0 : w_ext;
    assign bus.o_rsp_valid = (r_state != ST_IDLE);
    assign bus.o_rsp_rdata = (r_state == ST_HOLD) ? r_hold :
                             (r_state == ST_RESP) ? w_live : '0;
    assign bus.o_rsp_err   = bus.o_rsp_valid & r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_lane  <= '0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (w_accept) begin
                r_lane <= w_lane;
                r_size <= w_size;
                r_uns  <= bus.i_req_unsigned;
                r_we   <= bus.i_req_we;
                r_err  <= w_misalign;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (!bus.i_rsp_ready) begin
                        // Memory output is only valid this cycle; freeze it.
                        r_hold  <= w_live;
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= w_accept ? ST_RESP : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_rsp_ready) r_state <= w_accept ? ST_RESP : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_lsu_master
// Brief  : Scoreboard bench for dmem_lsu_master with a write-first memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_lsu_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_master_if #(.DATA_WIDTH(64)) bus ();

    dmem_lsu_master #(.DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mem [0:255];

    // Single-port synchronous memory, write-first, one cycle read latency.
    always @(posedge clk) begin : p_mem
        logic [63:0] w;
        w = mem[bus.o_mem_addr[10:3]];
        for (int b = 0; b < 8; b++)
            if (bus.o_mem_wen[b]) w[b*8 +: 8] = bus.o_mem_wdata[b*8 +: 8];
        mem[bus.o_mem_addr[10:3]] <= w;
        bus.i_mem_rdata <= w;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each handshake, checks stability while stalled.
    logic        held_v = 1'b0;
    logic [63:0] held_d;
    logic        held_e;
    always @(negedge clk) begin : p_mon
        rsp_t e;
        if (rst_n && bus.o_rsp_valid) begin
            if (held_v) begin
                check_val("hold_rdata_stable", bus.o_rsp_rdata, held_d);
                check_val("hold_err_stable", {63'b0, bus.o_rsp_err}, {63'b0, held_e});
            end
            if (!bus.i_rsp_ready) begin
                held_v = 1'b1;
                held_d = bus.o_rsp_rdata;
                held_e = bus.o_rsp_err;
            end else begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rsp_rdata", bus.o_rsp_rdata, e.rdata);
                    check_val("rsp_err", {63'b0, bus.o_rsp_err}, {63'b0, e.err});
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // Called at posedge+1; leaves the request valid so calls can run back-to-back.
    task automatic lsu_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] exp_wen, input logic [63:0] exp_rdata,
                           input logic exp_err);
        logic        acc;
        logic [63:0] exp_wd;
        bus.i_req_valid    = 1'b1;
        bus.i_req_we       = we;
        bus.i_req_size     = sz;
        bus.i_req_unsigned = uns;
        bus.i_req_addr     = addr;
        bus.i_req_wdata    = wdata;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            if (bus.o_req_ready) acc = 1'b1;
        end
        if (!acc) begin
            check_val("req_accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_wd = exp_err ? 64'd0 : (wdata << (8 * addr[2:0]));
            check_val("mem_addr", bus.o_mem_addr, exp_err ? 64'd0 : addr);
            check_val("mem_wen", {56'b0, bus.o_mem_wen}, {56'b0, exp_wen});
            check_val("mem_wdata", bus.o_mem_wdata, exp_wd);
            exp_q.push_back({exp_rdata, exp_err});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : p_main
        int stalls;
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        bus.i_req_valid    = 1'b0;
        bus.i_req_we       = 1'b0;
        bus.i_req_size     = 2'd0;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_addr     = 64'd0;
        bus.i_req_wdata    = 64'd0;
        bus.i_rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'd0);
        check_val("rst_rsp_err", {63'b0, bus.o_rsp_err}, 64'd0);
        check_val("rst_rsp_rdata", bus.o_rsp_rdata, 64'd0);
        check_val("rst_req_ready", {63'b0, bus.o_req_ready}, 64'd1);
        check_val("rst_mem_wen", {56'b0, bus.o_mem_wen}, 64'd0);
        check_val("rst_mem_addr", bus.o_mem_addr, 64'd0);
        @(posedge clk);
        #1;

        // Full-width store and load, then byte store merge.
        lsu_req(1, 2'd3, 0, 64'h100, 64'h1122334455667788, 8'hFF, 64'd0, 0);
        lsu_req(0, 2'd3, 0, 64'h100, 64'd0, 8'h00, 64'h1122334455667788, 0);
        lsu_req(1, 2'd0, 0, 64'h103, 64'h00000000000000AB, 8'h08, 64'd0, 0);
        lsu_req(0, 2'd3, 0, 64'h100, 64'd0, 8'h00, 64'h11223344AB667788, 0);

        // Sign / zero extension of narrow loads.
        lsu_req(1, 2'd3, 0, 64'h108, 64'h8000000000000080, 8'hFF, 64'd0, 0);
        lsu_req(0, 2'd0, 0, 64'h108, 64'd0, 8'h00, 64'hFFFFFFFFFFFFFF80, 0);
        lsu_req(0, 2'd0, 1, 64'h108, 64'd0, 8'h00, 64'h0000000000000080, 0);
        lsu_req(0, 2'd2, 0, 64'h10C, 64'd0, 8'h00, 64'hFFFFFFFF80000000, 0);
        lsu_req(0, 2'd2, 1, 64'h10C, 64'd0, 8'h00, 64'h0000000080000000, 0);
        lsu_req(0, 2'd1, 0, 64'h10E, 64'd0, 8'h00, 64'hFFFFFFFFFFFF8000, 0);
        lsu_req(0, 2'd1, 1, 64'h10E, 64'd0, 8'h00, 64'h0000000000008000, 0);

        // Misaligned accesses: answered with err, memory untouched.
        lsu_req(1, 2'd2, 0, 64'h102, 64'h00000000DEADBEEF, 8'h00, 64'd0, 1);
        lsu_req(0, 2'd2, 0, 64'h102, 64'd0, 8'h00, 64'd0, 1);
        lsu_req(1, 2'd1, 0, 64'h101, 64'h000000000000BEEF, 8'h00, 64'd0, 1);
        lsu_req(0, 2'd3, 0, 64'h100, 64'd0, 8'h00, 64'h11223344AB667788, 0);
        bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Three back-to-back loads with the consumer stalled on the first response.
        bus.i_rsp_ready = 1'b0;
        fork
            begin
                lsu_req(0, 2'd3, 0, 64'h100, 64'd0, 8'h00, 64'h11223344AB667788, 0);
                lsu_req(0, 2'd3, 0, 64'h108, 64'd0, 8'h00, 64'h8000000000000080, 0);
                lsu_req(0, 2'd0, 1, 64'h103, 64'd0, 8'h00, 64'h00000000000000AB, 0);
                bus.i_req_valid = 1'b0;
            end
            begin
                stalls = 0;
                for (int k = 0; k < 20 && stalls < 3; k++) begin
                    @(negedge clk);
                    if (bus.o_rsp_valid && !bus.i_rsp_ready) begin
                        stalls++;
                        check_val("stall_req_ready", {63'b0, bus.o_req_ready}, 64'd0);
                    end
                end
                @(posedge clk);
                #1 bus.i_rsp_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;

        // Asynchronous reset while a response is pending.
        bus.i_rsp_ready = 1'b0;
        lsu_req(0, 2'd3, 0, 64'h100, 64'd0, 8'h00, 64'h11223344AB667788, 0);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'd0);
        check_val("async_rst_rsp_rdata", bus.o_rsp_rdata, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        check_val("post_rst_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'd0);
        check_val("post_rst_req_ready", {63'b0, bus.o_req_ready}, 64'd1);
        @(posedge clk);
        #1;
        lsu_req(0, 2'd3, 0, 64'h108, 64'd0, 8'h00, 64'h8000000000000080, 0);
        bus.i_req_valid = 1'b0;

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) check_val("rsp_drain_timeout", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_lsu_master.md
Name: dmem_lsu_master

Overview:
- Load/store initiator that drives the single-port synchronous data memory: i_addr, i_wdata, byte-lane i_wen in; o_rdata out one cycle after the address edge, write-first.
- Accepts RISC-V style load/store requests from the core pipeline over a valid/ready channel.
- Generates byte-lane enables and shifted write data, and detects misalignment.
- Extracts, sign-extends or zero-extends load data, and returns one in-order response per request with backpressure.

Parameters:
- DATA_WIDTH, 64, memory word and register width.
- ADDR_WIDTH, DATA_WIDTH, request and memory address width.
- DATA_BYTES, DATA_WIDTH/8, byte lanes per word (power of two).
- LANE_BITS, $clog2(DATA_BYTES), low address bits selecting the lane.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- i_req_unsigned  in  1  zero-extend load (lbu/lhu/lwu).
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when valid & ready.
- o_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned request.
- o_mem_addr  out  ADDR_WIDTH  to memory i_addr.
- o_mem_wdata  out  DATA_WIDTH  to memory i_wdata.
- o_mem_wen  out  DATA_BYTES  to memory i_wen.
- i_mem_rdata  in  DATA_WIDTH  from memory o_rdata.

Behaviour:
- Reset values: state IDLE, o_rsp_valid 0, o_rsp_err 0, o_rsp_rdata 0, hold register 0.
- Reset is asynchronous. Assertion mid-operation discards any pending response. Writes already sampled by memory are not undone.
- FSM states:
  - IDLE: no response pending.
  - RESP: response driven live from i_mem_rdata.
  - HOLD: response driven from the captured hold register.
- o_req_ready = (state==IDLE) | i_rsp_ready. Combinational from i_rsp_ready, giving 1 request/cycle throughput.
- Accept in cycle N (valid & ready):
  - o_mem_addr = i_req_addr, combinational in cycle N.
  - o_mem_wen = (store & aligned) ? size_mask << lane : 0.
  - o_mem_wdata = i_req_wdata << (8*lane).
- Not accepting, or request misaligned:
  - o_mem_addr = 0, o_mem_wen = 0, o_mem_wdata = 0.
  - Never leave a stale address on the bus: reads of sim-control addresses have side effects.
- Lane and mask: lane = i_req_addr[LANE_BITS-1:0]; size_mask = (1<<(1<<size))-1.
- Misaligned when lane & ((1<<size)-1) != 0, or size exceeds log2(DATA_BYTES). Such a request is still accepted and answered.
- At accept, register lane, size, unsigned, we and err. Next state is RESP.
- Response in cycle N+1 (latency 1), o_rsp_valid = 1:
  - Load: o_rsp_rdata = extend((i_mem_rdata >> 8*lane)[8<<size -1:0]). Sign-extend unless unsigned or size==3.
  - Store or err: rdata = 0; err as registered.
- RESP with !i_rsp_ready: capture the extracted value into the hold register, go HOLD. Outputs stay stable while in HOLD (memory output may change).
- RESP/HOLD with i_rsp_ready:
  - new accept in same cycle → RESP;
  - no accept → IDLE.
- Simultaneous response handoff and new accept is legal. The new address goes out the same cycle the previous response completes.
- Ordering is strictly in-order. At most one outstanding response.

Decomposition:
- Package dmem_lsu_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_D), FSM state enum, size_mask and extend functions.
- One sub-module: dmem_lsu_extract, combinational shift/size/extend of load data.

Test Plan:
- sd 0x1122334455667788 @0x100, then ld @0x100 → wen 0xFF; rsp rdata 0x1122334455667788 at N+1, err 0.
- sb 0xAB @0x103 → wen 0x08, o_mem_wdata[31:24] = 0xAB; ld @0x100 → byte 3 = 0xAB, other bytes unchanged.
- Memory byte 0x80 @0x108:
  - lb → 0xFFFFFFFFFFFFFF80.
  - lbu → 0x80.
  - lw of 0x80000000 @0x10C → 0xFFFFFFFF80000000.
- lw @0x102 → err 1, rdata 0, wen held 0 for that cycle, memory contents unchanged.
- Three back-to-back lds, i_rsp_ready low 3 cycles after the first → o_req_ready 0 while stalled, first response held stable, all three returned in order with correct data.
- rst_n low while o_rsp_valid=1 → o_rsp_valid 0 immediately; after release state IDLE, o_req_ready 1, next ld correct.
